// File: rtl/wave_morph_engine.sv
// Wavetable morphing engine: time-multiplexed voices, two-stage pipeline
// (ROM address / fetch, then inversion, factor slew and crossfade mix).
module wave_morph_engine #(
    parameter int VOICES    = 4,
    parameter int SAMPLE_W  = 8,
    parameter int TABLE_AW  = 6,
    parameter int FACTOR_W  = 8,
    parameter int SLEW_STEP = 0,
    localparam int PW = TABLE_AW + 1,
    localparam int VW = (VOICES > 1) ? $clog2(VOICES) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ce,
    input  logic                         mirror_en,
    input  logic [VOICES*PW-1:0]         nco_phase,
    input  logic [VOICES*8-1:0]          wfm_num_l,
    input  logic [VOICES*8-1:0]          wfm_num_r,
    input  logic [VOICES*FACTOR_W-1:0]   factor,
    output logic                         rom_re,
    output logic [PW-1:0]                rom_addr,
    output logic [7:0]                   rom_wfm_l,
    output logic [7:0]                   rom_wfm_r,
    input  logic [SAMPLE_W-1:0]          rom_data_l,
    input  logic [SAMPLE_W-1:0]          rom_data_r,
    output logic [SAMPLE_W-1:0]          sample_out,
    output logic [VW-1:0]                sample_voice,
    output logic                         sample_valid,
    output logic                         frame_done
);

    localparam int MW = SAMPLE_W + FACTOR_W + 1;
    localparam logic [VW-1:0]         LAST_V = VW'(VOICES - 1);
    localparam logic [TABLE_AW-1:0]   TOP_A  = '1;
    localparam logic [SAMPLE_W-1:0]   TOP_S  = '1;
    localparam logic [MW-1:0]         FULL_F = MW'(2 ** FACTOR_W);
    localparam logic [FACTOR_W:0]     STEP_V = (FACTOR_W + 1)'(SLEW_STEP);

    // ------------------------------------------------------------------
    // Stage A: voice select and ROM address generation
    // ------------------------------------------------------------------
    logic [VW-1:0]        vcnt_q, vcnt_d;
    logic [PW-1:0]        phase_a;
    logic [TABLE_AW-1:0]  pofs_a;
    logic                 half_a;
    logic [FACTOR_W-1:0]  tgt_a;

    always_comb begin
        phase_a   = nco_phase[int'(vcnt_q)*PW +: PW];
        tgt_a     = factor[int'(vcnt_q)*FACTOR_W +: FACTOR_W];
        rom_wfm_l = wfm_num_l[int'(vcnt_q)*8 +: 8];
        rom_wfm_r = wfm_num_r[int'(vcnt_q)*8 +: 8];
        // Upper half of the cycle replays the half-table backwards and
        // is inverted in stage B, giving an odd-symmetric waveform.
        half_a    = mirror_en & phase_a[PW-1];
        pofs_a    = half_a ? (TOP_A - phase_a[TABLE_AW-1:0]) : phase_a[TABLE_AW-1:0];
        rom_addr  = mirror_en ? {1'b0, pofs_a} : phase_a;
        rom_re    = ce & rst_n;
        vcnt_d    = (vcnt_q == LAST_V) ? '0 : vcnt_q + 1'b1;
    end

    // Valid semantics: b_valid_q / sample_valid mark a qualified sample;
    // there is no back-pressure, the pipeline advances on every ce=1 edge
    // and the consumer must take sample_out in the cycle sample_valid=1.
    logic                 b_valid_q;
    logic [VW-1:0]        b_voice_q;
    logic                 b_half_q;
    logic [FACTOR_W-1:0]  b_tgt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vcnt_q    <= '0;
            b_valid_q <= 1'b0;
            b_voice_q <= '0;
            b_half_q  <= 1'b0;
            b_tgt_q   <= '0;
        end else if (ce) begin
            vcnt_q    <= vcnt_d;
            b_valid_q <= 1'b1;
            b_voice_q <= vcnt_q;
            b_half_q  <= half_a;
            b_tgt_q   <= tgt_a;
        end
    end

    // ------------------------------------------------------------------
    // Stage B: inversion, factor slew, crossfade
    // ------------------------------------------------------------------
    logic [FACTOR_W-1:0]  fcur_q [VOICES];
    logic [FACTOR_W-1:0]  fcur_b;
    logic [FACTOR_W-1:0]  f_new;
    logic [FACTOR_W:0]    diff_b;
    logic                 up_b;
    logic [SAMPLE_W-1:0]  l_b, r_b;
    logic [MW-1:0]        mix_sum;
    logic [SAMPLE_W-1:0]  sample_d;

    always_comb begin
        l_b    = b_half_q ? (TOP_S - rom_data_l) : rom_data_l;
        r_b    = b_half_q ? (TOP_S - rom_data_r) : rom_data_r;
        fcur_b = fcur_q[b_voice_q];
        up_b   = b_tgt_q > fcur_b;
        diff_b = up_b ? ({1'b0, b_tgt_q} - {1'b0, fcur_b})
                      : ({1'b0, fcur_b} - {1'b0, b_tgt_q});
        if ((SLEW_STEP == 0) || (diff_b <= STEP_V)) begin
            f_new = b_tgt_q;
        end else if (up_b) begin
            f_new = fcur_b + STEP_V[FACTOR_W-1:0];
        end else begin
            f_new = fcur_b - STEP_V[FACTOR_W-1:0];
        end
        // Each weighted term is below 2^(SAMPLE_W+FACTOR_W), so the sum
        // cannot overflow MW bits and the shifted result fits SAMPLE_W.
        mix_sum  = (FULL_F - MW'(f_new)) * MW'(l_b) + MW'(f_new) * MW'(r_b);
        sample_d = SAMPLE_W'(mix_sum >> FACTOR_W);
    end

    for (genvar v = 0; v < VOICES; v++) begin : g_fcur
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                fcur_q[v] <= '0;
            end else if (ce && b_valid_q && (b_voice_q == VW'(v))) begin
                fcur_q[v] <= f_new;
            end
        end
    end

    logic [SAMPLE_W-1:0]  sample_out_q;
    logic [VW-1:0]        sample_voice_q;
    logic                 sample_valid_q;
    logic                 frame_done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_out_q   <= '0;
            sample_voice_q <= '0;
            sample_valid_q <= 1'b0;
            frame_done_q   <= 1'b0;
        end else if (ce) begin
            sample_valid_q <= b_valid_q;
            frame_done_q   <= b_valid_q & (b_voice_q == LAST_V);
            if (b_valid_q) begin
                sample_out_q   <= sample_d;
                sample_voice_q <= b_voice_q;
            end
        end else begin
            sample_valid_q <= 1'b0;
            frame_done_q   <= 1'b0;
        end
    end

    assign sample_out   = sample_out_q;
    assign sample_voice = sample_voice_q;
    assign sample_valid = sample_valid_q;
    assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_wave_morph_engine.sv
// Bench for wave_morph_engine: two instances (no slew, slew step 4) share
// stimulus; a scoreboard queue per instance is drained by a monitor process.
module tb_wave_morph_engine;

  localparam int V  = 4;
  localparam int PW = 7;
  localparam int SW = 8;
  localparam int FW = 8;
  localparam int VW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ce = 1'b1;
  logic mirror_en = 1'b1;
  logic [V*PW-1:0] nco_phase;
  logic [V*8-1:0] wfm_l, wfm_r;
  logic [V*FW-1:0] factor;

  logic rom_re0, rom_re1;
  logic [PW-1:0] rom_addr0, rom_addr1;
  logic [7:0] wfl0, wfr0, wfl1, wfr1;
  logic [SW-1:0] dl0, dr0, dl1, dr1, so0, so1;
  logic [VW-1:0] sv0, sv1;
  logic val0, val1, fd0, fd1;

  logic [PW-1:0] ph_a [V];
  logic [FW-1:0] tg_a [V];
  logic [7:0] wl_a [V];
  logic [7:0] wr_a [V];
  int rom_mode = 0;

  logic [FW-1:0] fm [2][V];
  int mvc = 0;
  int drv_cnt = 0;
  int mon_cnt = 0;
  logic ce_s, rst_s;
  logic [26:0] exp_q0[$];
  logic [26:0] exp_q1[$];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  always_comb begin
    nco_phase = '0;
    wfm_l = '0;
    wfm_r = '0;
    factor = '0;
    for (int v = 0; v < V; v++) begin
      nco_phase[v*PW +: PW] = ph_a[v];
      wfm_l[v*8 +: 8] = wl_a[v];
      wfm_r[v*8 +: 8] = wr_a[v];
      factor[v*FW +: FW] = tg_a[v];
    end
  end

  wave_morph_engine dut0 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .mirror_en(mirror_en),
    .nco_phase(nco_phase), .wfm_num_l(wfm_l), .wfm_num_r(wfm_r), .factor(factor),
    .rom_re(rom_re0), .rom_addr(rom_addr0), .rom_wfm_l(wfl0), .rom_wfm_r(wfr0),
    .rom_data_l(dl0), .rom_data_r(dr0),
    .sample_out(so0), .sample_voice(sv0), .sample_valid(val0), .frame_done(fd0)
  );

  wave_morph_engine #(.SLEW_STEP(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .mirror_en(mirror_en),
    .nco_phase(nco_phase), .wfm_num_l(wfm_l), .wfm_num_r(wfm_r), .factor(factor),
    .rom_re(rom_re1), .rom_addr(rom_addr1), .rom_wfm_l(wfl1), .rom_wfm_r(wfr1),
    .rom_data_l(dl1), .rom_data_r(dr1),
    .sample_out(so1), .sample_voice(sv1), .sample_valid(val1), .frame_done(fd1)
  );

  // ROM models: mode 0 is data_l = addr, data_r = 255-addr; mode 1 is 100/200.
  function automatic logic [7:0] rom_l(input logic [PW-1:0] a, input int m);
    if (m == 1) return 8'd100;
    return 8'(a);
  endfunction

  function automatic logic [7:0] rom_r(input logic [PW-1:0] a, input int m);
    if (m == 1) return 8'd200;
    return 8'd255 - 8'(a);
  endfunction

  always @(posedge clk) begin
    if (rom_re0) begin
      dl0 <= rom_l(rom_addr0, rom_mode);
      dr0 <= rom_r(rom_addr0, rom_mode);
    end
    if (rom_re1) begin
      dl1 <= rom_l(rom_addr1, rom_mode);
      dr1 <= rom_r(rom_addr1, rom_mode);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] slew_f(input logic [7:0] cur, input logic [7:0] tgt, input int step);
    int c, t, d;
    c = int'(cur);
    t = int'(tgt);
    d = (t > c) ? t - c : c - t;
    if (step == 0 || d <= step) return tgt;
    if (t > c) return 8'(c + step);
    return 8'(c - step);
  endfunction

  // Expected entry: {due ce-edge[26:11], frame_done[10], voice[9:8], sample[7:0]}
  task automatic push_model();
    int ph, half, addr, dlv, drv, l, r, f, out, step;
    logic [26:0] e;
    ph = int'(ph_a[mvc]);
    half = mirror_en ? ((ph >> 6) & 1) : 0;
    if (!mirror_en) addr = ph;
    else if (half == 1) addr = 63 - (ph & 63);
    else addr = ph & 63;
    dlv = (rom_mode == 1) ? 100 : addr;
    drv = (rom_mode == 1) ? 200 : 255 - addr;
    l = (half == 1) ? 255 - dlv : dlv;
    r = (half == 1) ? 255 - drv : drv;
    for (int i = 0; i < 2; i++) begin
      step = (i == 0) ? 0 : 4;
      fm[i][mvc] = slew_f(fm[i][mvc], tg_a[mvc], step);
      f = int'(fm[i][mvc]);
      out = ((256 - f) * l + f * r) / 256;
      e = {16'(drv_cnt + 1), (mvc == V - 1), 2'(mvc), 8'(out)};
      if (i == 0) exp_q0.push_back(e);
      else exp_q1.push_back(e);
    end
    mvc = (mvc + 1) % V;
  endtask

  // One clock: drive at negedge, record expectation, return just after posedge.
  task automatic cyc(input logic ce_v);
    @(negedge clk);
    ce = ce_v;
    if (ce_v && rst_n) begin
      drv_cnt++;
      push_model();
    end
    @(posedge clk);
    #2;
  endtask

  task automatic model_reset();
    exp_q0.delete();
    exp_q1.delete();
    mvc = 0;
    drv_cnt = 0;
    for (int i = 0; i < 2; i++)
      for (int v = 0; v < V; v++) fm[i][v] = '0;
  endtask

  task automatic pop_cmp(input int i, input logic [SW-1:0] so, input logic [VW-1:0] sv, input logic fd);
    logic [26:0] e;
    if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
      total++;
      bad++;
      $display("FAIL dut%0d_unexpected_valid: got sample %0d, want no sample", i, so);
      return;
    end
    if (i == 0) e = exp_q0.pop_front();
    else e = exp_q1.pop_front();
    chk($sformatf("dut%0d_sample", i), so, e[7:0]);
    chk($sformatf("dut%0d_voice", i), sv, e[9:8]);
    chk($sformatf("dut%0d_frame_done", i), fd, e[10]);
    chk($sformatf("dut%0d_latency_edge", i), mon_cnt, e[26:11]);
  endtask

  // Monitor
  initial begin
    forever begin
      @(posedge clk);
      ce_s = ce;
      rst_s = rst_n;
      #1;
      if (!rst_s) begin
        mon_cnt = 0;
        chk("reset_valid", {val1, val0, fd1, fd0}, 0);
      end else if (!ce_s) begin
        chk("idle_valid", {val1, val0, fd1, fd0}, 0);
      end else begin
        mon_cnt++;
        if (val0) pop_cmp(0, so0, sv0, fd0);
        else if (exp_q0.size() > 0 && int'(exp_q0[0][26:11]) == mon_cnt) begin
          total++;
          bad++;
          $display("FAIL dut0_missing_valid: got 0, want 1 at ce edge %0d", mon_cnt);
        end
        if (val1) pop_cmp(1, so1, sv1, fd1);
        else if (exp_q1.size() > 0 && int'(exp_q1[0][26:11]) == mon_cnt) begin
          total++;
          bad++;
          $display("FAIL dut1_missing_valid: got 0, want 1 at ce edge %0d", mon_cnt);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    for (int v = 0; v < V; v++) begin
      ph_a[v] = 7'h45;
      tg_a[v] = '0;
      wl_a[v] = 8'(8'h10 + v);
      wr_a[v] = 8'(8'h20 + v);
    end
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    chk("reset_rom_re", {rom_re1, rom_re0}, 0);
    chk("reset_sample_out", so0, 0);
    chk("reset_sample_voice", sv0, 0);

    // Release; stage-A address for voice 0, phase 0x45
    ce = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("mirror_addr_dut0", rom_addr0, 58);
    chk("mirror_addr_dut1", rom_addr1, 58);
    chk("wfm_l_voice0", wfl0, 8'h10);
    chk("wfm_r_voice0", wfr0, 8'h20);
    mirror_en = 1'b0;
    #1;
    chk("full_addr", rom_addr0, 7'h45);
    mirror_en = 1'b1;

    cyc(1'b1);
    chk("first_edge_no_valid", val0, 0);
    cyc(1'b1);
    chk("mirror_sample_dut0", so0, 197);
    chk("mirror_sample_dut1", so1, 197);
    chk("mirror_voice", sv0, 0);
    chk("wfm_l_voice2", wfl0, 8'h12);
    chk("wfm_r_voice2", wfr0, 8'h22);

    // Mirror mode toggled every sample with varied phases and targets
    for (int k = 0; k < 16; k++) begin
      mirror_en = k[0];
      for (int v = 0; v < V; v++) begin
        ph_a[v] = 7'((k * 29 + v * 17 + 3) % 128);
        tg_a[v] = 8'((k * 53 + v * 91) % 256);
      end
      cyc(1'b1);
    end

    // Crossfade of l=100, r=200 at three factors
    rom_mode = 1;
    mirror_en = 1'b0;
    for (int v = 0; v < V; v++) tg_a[v] = 8'd128;
    repeat (8) cyc(1'b1);
    chk("mix_f128", so0, 150);
    for (int v = 0; v < V; v++) tg_a[v] = 8'd255;
    repeat (8) cyc(1'b1);
    chk("mix_f255", so0, 199);
    for (int v = 0; v < V; v++) tg_a[v] = 8'd0;
    repeat (8) cyc(1'b1);
    chk("mix_f0", so0, 100);

    // Clock enable every other cycle
    rom_mode = 0;
    for (int k = 0; k < 24; k++) begin
      mirror_en = k[1];
      for (int v = 0; v < V; v++) begin
        ph_a[v] = 7'((k * 11 + v * 37) % 128);
        tg_a[v] = 8'((k * 19 + v * 67) % 256);
      end
      cyc(1'b1);
      cyc(1'b0);
    end

    // Mid-frame reset, then slew ramp on voice 0 only
    rom_mode = 1;
    mirror_en = 1'b0;
    for (int v = 0; v < V; v++) tg_a[v] = 8'd0;
    tg_a[0] = 8'd255;
    repeat (6) cyc(1'b1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midreset_sample_out", {so1, so0}, 0);
    chk("midreset_valid", {val1, val0, fd1, fd0}, 0);
    chk("midreset_voice", {sv1, sv0}, 0);
    chk("midreset_rom_re", {rom_re1, rom_re0}, 0);
    repeat (2) @(posedge clk);
    #2;
    ce = 1'b0;
    rst_n = 1'b1;
    cyc(1'b1);
    chk("rst_first_edge_no_valid", val0, 0);
    cyc(1'b1);
    chk("rst_first_valid", val0, 1);
    chk("rst_first_voice", sv0, 0);
    chk("rst_noslew_f255", so0, 199);
    chk("rst_slew_f4", so1, 101);
    repeat (248) cyc(1'b1);
    chk("slew_63rd_voice", sv1, 0);
    chk("slew_63rd_f252", so1, 198);
    repeat (4) cyc(1'b1);
    chk("slew_64th_voice", sv1, 0);
    chk("slew_64th_f255", so1, 199);

    // Exactly the sample sitting in stage B remains outstanding
    chk("final_queue0", exp_q0.size(), 1);
    chk("final_queue1", exp_q1.size(), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wave_morph_engine.md
WAVE_MORPH_ENGINE -- requirements
Module: wave_morph_engine

Interface
REQ-001 The block SHALL have parameter VOICES, default 4, giving the number of time-multiplexed voices (1..16).
REQ-002 The block SHALL have parameter SAMPLE_W, default 8, giving the sample width.
REQ-003 The block SHALL have parameter TABLE_AW, default 6, giving log2 of samples per half-table.
REQ-004 The block SHALL have parameter FACTOR_W, default 8, giving the morph factor width.
REQ-005 The block SHALL have parameter SLEW_STEP, default 0, giving the maximum factor change per voice update; 0 means no slew.
REQ-006 The block SHALL have the following ports; PW = TABLE_AW+1 and VW = max(1,clog2(VOICES)):
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- ce, in, 1: clock enable; all state advances only when ce=1.
- mirror_en, in, 1: 1 selects half-table mirror mode, 0 selects full-table mode.
- nco_phase, in, VOICES*PW: per-voice phase, voice v at bits [v*PW +: PW].
- wfm_num_l, in, VOICES*8: per-voice left waveform number.
- wfm_num_r, in, VOICES*8: per-voice right waveform number.
- factor, in, VOICES*FACTOR_W: per-voice target morph factor.
- rom_re, out, 1: ROM read enable.
- rom_addr, out, PW: ROM sample address, shared by both ports.
- rom_wfm_l, out, 8: left ROM waveform select.
- rom_wfm_r, out, 8: right ROM waveform select.
- rom_data_l, in, SAMPLE_W: left ROM data, valid one ce-edge after rom_re.
- rom_data_r, in, SAMPLE_W: right ROM data, valid one ce-edge after rom_re.
- sample_out, out, SAMPLE_W: morphed sample.
- sample_voice, out, VW: voice index of sample_out.
- sample_valid, out, 1: one-clk pulse marking a new sample_out.
- frame_done, out, 1: pulses with sample_valid when sample_voice = VOICES-1.

Function
REQ-007 Voice counter SHALL advance 0..VOICES-1 on each clk edge with ce=1 and wrap to 0; it SHALL hold when ce=0.
REQ-008 Stage A (combinational, same cycle): select voice v fields; rom_re = ce; rom_wfm_l/r = the voice's wfm_num_l/r.
REQ-009 Mirror mode: half = phase[PW-1]; rom_addr = {1'b0, half ? (2^TABLE_AW-1 - phase[TABLE_AW-1:0]) : phase[TABLE_AW-1:0]}.
REQ-010 Full mode: rom_addr = phase unchanged; half = 0.
REQ-011 On a ce edge, stage A SHALL register voice index, half, target factor and a valid bit into stage B; mirror_en SHALL therefore apply per sample.
REQ-012 Stage B SHALL set l = half ? (2^SAMPLE_W-1 - rom_data_l) : rom_data_l, and treat r identically with rom_data_r.
REQ-013 Per-voice register fcur[v]: if |target - fcur| <= SLEW_STEP or SLEW_STEP = 0, next = target; otherwise next = fcur +/- SLEW_STEP toward target; the update SHALL occur only on a stage-B ce edge with valid=1.
REQ-014 Mix SHALL use the updated factor f: out = ((2^FACTOR_W - f)*l + f*r) >> FACTOR_W, computed at full width SAMPLE_W+FACTOR_W+1 with no overflow; the result SHALL fit in SAMPLE_W bits.
REQ-015 On the stage-B ce edge: sample_out = out, sample_voice = stage-B voice, sample_valid = stage-B valid, frame_done = valid & (voice = VOICES-1).
REQ-016 Latency SHALL be exactly 2 ce edges from phase sampling to sample_out.
REQ-017 sample_valid and frame_done SHALL be forced to 0 on any clk edge with ce=0; sample_out and sample_voice SHALL hold.
REQ-018 With ce=1 continuously, after fill, sample_valid SHALL be 1 every cycle and frame_done SHALL pulse every VOICES cycles.
REQ-019 ROM contract: the ROM registers data on a clk edge with re=1 and holds otherwise.

Reset
REQ-020 While rst_n=0, all registers SHALL be 0: voice counter, pipeline valid, fcur[*], sample_out, sample_voice, sample_valid, frame_done.
REQ-021 While rst_n=0, rom_re SHALL be 0.
REQ-022 Reset asserted mid-stream SHALL discard in-flight samples.
REQ-023 After reset release, the first sample_valid SHALL occur on the 2nd ce edge, with voice 0.

Verification
REQ-024 ROM model: data_l = addr, data_r = 255-addr; defaults; mirror_en=1; factor=0; voice0 phase 0x45 -> rom_addr 58, sample_out 197, sample_voice 0.
REQ-025 l=100, r=200, factor=128, SLEW_STEP=0 -> sample_out 150; factor=255 -> 199; factor=0 -> 100.
REQ-026 SLEW_STEP=4, voice0 target 0->255 -> successive voice-0 mixes use f = 4, 8, ... 252, 255; 255 is reached on the 64th update, and other voices are unaffected.
REQ-027 mirror_en=0, phase 0x45 -> rom_addr 0x45, no inversion; toggle mirror_en every cycle -> each sample follows its own stage-A mode.
REQ-028 ce high every other cycle -> identical sample sequence; no state change and sample_valid=0 on ce=0 cycles; frame_done every 2*VOICES cycles.
REQ-029 rst_n pulsed low mid-frame -> outputs 0 immediately; after release, first valid on 2nd ce edge with voice 0 and fcur restarting from 0.
